// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b LSB first, one bit per clock,
// with a single full-subtractor cell and one borrow flip-flop.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic             brw_ff;
    logic [CW-1:0]    cnt;
    logic             d_bit, b_out, last_bit;

    // Full-subtractor cell on the current LSBs of the operand shift registers.
    assign d_bit    = a_sr[0] ^ b_sr[0] ^ brw_ff;
    assign b_out    = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw_ff);
    assign last_bit = (cnt == CW'(WIDTH - 1));

    // NOTE: next state gets a default before the case so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: every register, shift registers included, is cleared by rst so an
    // aborted operation leaves no stale partial result behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            brw_ff <= 1'b0;
            cnt    <= '0;
        end else begin
            // NOTE: non-blocking assignments keep all state updates simultaneous.
            state <= state_nxt;
            busy  <= (state_nxt == RUN);
            done  <= (state_nxt == FIN);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        brw_ff <= 1'b0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    res_sr <= {d_bit, res_sr[WIDTH-1:1]};
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    brw_ff <= b_out;
                    cnt    <= cnt + CW'(1);
                    // Outputs update only once the final bit is known.
                    if (last_bit) begin
                        diff   <= {d_bit, res_sr[WIDTH-1:1]};
                        borrow <= b_out;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized bench for serial_subtractor at WIDTH=8 and WIDTH=16.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, start16;
    logic [7:0]  a8, b8, diff8;
    logic [15:0] a16, b16, diff16;
    logic        busy8, done8, borrow8;
    logic        busy16, done16, borrow16;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
    );

    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .diff(diff16), .borrow(borrow16)
    );

    // Called at a negedge while idle. Returns at the first IDLE negedge after done.
    // lat counts edges from the accepting edge (inclusive) to the edge raising done.
    task automatic op8(input logic [7:0] aa, input logic [7:0] bb,
                       output logic [7:0] d, output logic br,
                       output int lat, output int done_cyc);
        logic [7:0] prev;
        bit seen, moved;
        start8 = 1'b1; a8 = aa; b8 = bb; prev = diff8;
        @(negedge clk);
        start8 = 1'b0; a8 = ~aa; b8 = ~bb;
        checks++;
        if (busy8 !== 1'b1) begin
            errors++; $display("FAIL op8_accept busy=%b expected 1", busy8);
        end
        lat = 1; seen = 0; moved = 0;
        while (!seen && lat < 40) begin
            if (done8 === 1'b1) seen = 1;
            else begin
                if (diff8 !== prev) moved = 1;
                @(negedge clk); lat++;
            end
        end
        d = diff8; br = borrow8; done_cyc = cyc;
        checks++;
        if (!seen) begin
            errors++; $display("FAIL op8_timeout done never seen in %0d edges", lat);
        end
        checks++;
        if (moved) begin
            errors++; $display("FAIL op8_diff_hold diff toggled during RUN, was %h", prev);
        end
        @(negedge clk);
        checks++;
        if (done8 !== 1'b0 || busy8 !== 1'b0) begin
            errors++; $display("FAIL op8_done_pulse done=%b busy=%b expected 0 0", done8, busy8);
        end
    endtask

    task automatic op16(input logic [15:0] aa, input logic [15:0] bb,
                        output logic [15:0] d, output logic br);
        int n;
        start16 = 1'b1; a16 = aa; b16 = bb;
        @(negedge clk);
        start16 = 1'b0; a16 = ~aa; b16 = ~bb;
        n = 1;
        while (done16 !== 1'b1 && n < 60) begin
            @(negedge clk); n++;
        end
        d = diff16; br = borrow16;
        checks++;
        if (n != 17) begin
            errors++; $display("FAIL op16_latency edges=%0d expected 17", n);
        end
        @(negedge clk);
    endtask

    task automatic idle_no_done(input int n, input string name);
        bit hit = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done8 === 1'b1 || busy8 === 1'b1) hit = 1;
        end
        checks++;
        if (hit) begin
            errors++; $display("FAIL %s unexpected done/busy while idle", name);
        end
    endtask

    task automatic test_reset();
        logic [7:0] d; logic br; int lat, dc;
        rst = 1'b1; start8 = 1'b0; start16 = 1'b0;
        a8 = '0; b8 = '0; a16 = '0; b16 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || diff8 !== 8'h00 || borrow8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state busy=%b done=%b diff=%h borrow=%b expected 0 0 00 0",
                     busy8, done8, diff8, borrow8);
        end
        // rst wins over a coincident start.
        start8 = 1'b1; a8 = 8'h12; b8 = 8'h01;
        @(negedge clk);
        start8 = 1'b0;
        checks++;
        if (busy8 !== 1'b0) begin
            errors++; $display("FAIL reset_priority busy=%b expected 0", busy8);
        end
        // First edge with rst low accepts start; this is the 0x5A - 0x23 vector.
        rst = 1'b0;
        op8(8'h5A, 8'h23, d, br, lat, dc);
        checks++;
        if (d !== 8'h37 || br !== 1'b0) begin
            errors++; $display("FAIL basic_5a_23 diff=%h borrow=%b expected 37 0", d, br);
        end
        checks++;
        if (lat != 9) begin
            errors++; $display("FAIL basic_latency edges=%0d expected 9", lat);
        end
    endtask

    task automatic test_vectors();
        logic [7:0] va [3] = '{8'h10, 8'h00, 8'hFF};
        logic [7:0] vb [3] = '{8'h20, 8'h01, 8'hFF};
        logic [7:0] ed [3] = '{8'hF0, 8'hFF, 8'h00};
        logic       eb [3] = '{1'b1, 1'b1, 1'b0};
        logic [7:0] d; logic br; int lat, dc;
        for (int i = 0; i < 3; i++) begin
            op8(va[i], vb[i], d, br, lat, dc);
            checks++;
            if (d !== ed[i] || br !== eb[i]) begin
                errors++;
                $display("FAIL vector_%0d diff=%h borrow=%b expected %h %b", i, d, br, ed[i], eb[i]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int n = 0;
        start8 = 1'b1; a8 = 8'h80; b8 = 8'h01;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        start8 = 1'b1; a8 = 8'h00; b8 = 8'h00;
        @(negedge clk);
        start8 = 1'b0;
        while (done8 !== 1'b1 && n < 40) begin
            @(negedge clk); n++;
        end
        checks++;
        if (done8 !== 1'b1 || busy8 !== 1'b0 || diff8 !== 8'h7F || borrow8 !== 1'b0) begin
            errors++;
            $display("FAIL ignore_run done=%b busy=%b diff=%h borrow=%b expected 1 0 7f 0",
                     done8, busy8, diff8, borrow8);
        end
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || diff8 !== 8'h7F) begin
            errors++;
            $display("FAIL ignore_fin busy=%b done=%b diff=%h expected 0 0 7f", busy8, done8, diff8);
        end
        idle_no_done(12, "ignore_not_queued");
    endtask

    task automatic test_reset_abort();
        logic [7:0] d; logic br; int lat, dc;
        start8 = 1'b1; a8 = 8'h33; b8 = 8'h11;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || diff8 !== 8'h00 || borrow8 !== 1'b0) begin
            errors++;
            $display("FAIL abort_state busy=%b done=%b diff=%h borrow=%b expected 0 0 00 0",
                     busy8, done8, diff8, borrow8);
        end
        idle_no_done(12, "abort_no_done");
        op8(8'h33, 8'h11, d, br, lat, dc);
        checks++;
        if (d !== 8'h22 || br !== 1'b0) begin
            errors++; $display("FAIL abort_restart diff=%h borrow=%b expected 22 0", d, br);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d1, d2; logic b1, b2; int lat, dc1, dc2;
        op8(8'hC3, 8'h3C, d1, b1, lat, dc1);
        op8(8'h3C, 8'hC3, d2, b2, lat, dc2);
        checks++;
        if (d1 !== 8'h87 || b1 !== 1'b0) begin
            errors++; $display("FAIL b2b_first diff=%h borrow=%b expected 87 0", d1, b1);
        end
        checks++;
        if (d2 !== 8'h79 || b2 !== 1'b1) begin
            errors++; $display("FAIL b2b_second diff=%h borrow=%b expected 79 1", d2, b2);
        end
        checks++;
        if (dc2 - dc1 != 10) begin
            errors++; $display("FAIL b2b_interval cycles=%0d expected 10", dc2 - dc1);
        end
    endtask

    task automatic test_random();
        logic [7:0] ra, rb, d; logic [15:0] sa, sb, d16; logic br;
        logic [8:0] exp9; logic [16:0] exp17; int lat, dc;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            exp9 = {1'b0, ra} - {1'b0, rb};
            op8(ra, rb, d, br, lat, dc);
            checks++;
            if ({br, d} !== exp9) begin
                errors++;
                $display("FAIL rand8 a=%h b=%h got %b_%h expected %b_%h", ra, rb, br, d, exp9[8], exp9[7:0]);
            end
        end
        for (int i = 0; i < 1000; i++) begin
            sa = 16'($urandom); sb = 16'($urandom);
            exp17 = {1'b0, sa} - {1'b0, sb};
            op16(sa, sb, d16, br);
            checks++;
            if ({br, d16} !== exp17) begin
                errors++;
                $display("FAIL rand16 a=%h b=%h got %b_%h expected %b_%h", sa, sb, br, d16, exp17[16], exp17[15:0]);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_vectors();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001: Parameter WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002: clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-003: rst  input  1  reset, synchronous, active-high.
REQ-004: start  input  1  request pulse; sampled on the rising edge of clk.
REQ-005: a  input  WIDTH  minuend, unsigned; sampled only on the edge that accepts start.
REQ-006: b  input  WIDTH  subtrahend, unsigned; sampled only on the edge that accepts start.
REQ-007: busy  output  1  high while a subtraction is in progress.
REQ-008: done  output  1  single-cycle pulse marking valid diff and borrow.
REQ-009: diff  output  WIDTH  result (a - b) mod 2^WIDTH.
REQ-010: borrow  output  1  final borrow; high when a < b (unsigned).

Function
REQ-011: The block SHALL compute a - b bit-serially, LSB first, one bit per clock, using one full-subtractor cell and one borrow flip-flop.
REQ-012: Per-bit cell: d = ai ^ bi ^ bin; bout = (~ai & bi) | (~(ai ^ bi) & bin).
REQ-013: FSM states SHALL be IDLE, RUN and FIN, and the FSM SHALL have no other reachable states.
REQ-014: IDLE -> RUN on an edge with start=1: load a and b into operand shift registers, clear the borrow flip-flop, clear the bit counter.
REQ-015: RUN: each edge SHALL shift one result bit into the MSB of a result shift register, shift both operand registers right by one, update the borrow flip-flop and increment the counter.
REQ-016: RUN -> FIN on the edge that processes bit WIDTH-1, i.e. exactly WIDTH edges in RUN.
REQ-017: On the RUN -> FIN edge, diff and borrow SHALL be loaded from the completed result and final borrow.
REQ-018: FIN -> IDLE unconditionally after one cycle.
REQ-019: busy SHALL be 1 in RUN and 0 in IDLE and FIN.
REQ-020: done SHALL be 1 only in FIN.
REQ-021: Latency: with start accepted at edge T0, done SHALL be high during the cycle after edge T0+WIDTH.
REQ-022: The minimum issue interval SHALL be WIDTH+2 cycles.
REQ-023: start SHALL be ignored in RUN and FIN, with no effect on the operation in progress and not queued.
REQ-024: Changes on a and b after acceptance SHALL NOT affect the result.
REQ-025: diff and borrow SHALL hold their last completed values until the next RUN -> FIN edge and SHALL NOT toggle during RUN.
REQ-026: Boundary: a = b SHALL give diff = 0, borrow = 0.
REQ-027: Boundary: a = 0, b = 2^WIDTH-1 SHALL give diff = 1, borrow = 1.
REQ-028: The block SHALL use no combinational path from inputs to outputs, and all outputs SHALL be registered.

Reset
REQ-029: rst=1 at a rising edge SHALL force state IDLE, and clear busy, done, diff, borrow, the borrow flip-flop, the counter and the shift registers.
REQ-030: rst SHALL take priority over start, including on the same edge.
REQ-031: rst asserted mid-RUN SHALL abort the operation with no done pulse, and diff and borrow SHALL be 0.
REQ-032: The first start SHALL be accepted on the first edge with rst=0.

Verification
REQ-033: WIDTH=8, a=0x5A, b=0x23, start for one cycle -> done exactly 9 edges after acceptance, diff=0x37, borrow=0.
REQ-034: a=0x10, b=0x20 -> diff=0xF0, borrow=1; then a=0x00, b=0x01 -> diff=0xFF, borrow=1; then a=0xFF, b=0xFF -> diff=0x00, borrow=0.
REQ-035: Accept a=0x80, b=0x01; pulse start with a=0x00, b=0x00 on RUN cycle 3 and again during FIN -> both pulses ignored, single done, diff=0x7F, busy low in FIN.
REQ-036: Accept a=0x33, b=0x11; assert rst on RUN cycle 4 -> no done, busy=0, diff=0x00, borrow=0; next start a=0x33, b=0x11 -> diff=0x22.
REQ-037: Back-to-back: start re-asserted on the first IDLE cycle after FIN -> accepted; two done pulses WIDTH+2 cycles apart with correct diff and borrow.
REQ-038: Randomized check: 1000 random a/b pairs against the reference model {borrow, diff} = {1'b0, a} - {1'b0, b} for WIDTH=8 and WIDTH=16.
